// File: rtl/regfile_shift_capture.sv
// rtl/regfile_shift_capture.sv - serial-to-parallel receiver with double-buffered valid/ready word output
module regfile_shift_capture #(
    parameter int DATA_WIDTH = 192,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  shift_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic [CNT_WIDTH-1:0]  bit_cnt,
    output logic                  overrun,
    input  logic                  clr_overrun
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_e;

    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

    buf_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  ovr_q, ovr_d;
    logic [DATA_WIDTH-1:0] word;
    logic                  wc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            shift_q <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        wc      = 1'b0;
        word    = {shift_q[DATA_WIDTH-2:0], shift_in};
        if (en) begin
            shift_d = word;
            if (cnt_q == LAST_BIT) begin
                wc    = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // A drop sets overrun after the clear is applied, so a same-cycle set wins.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        ovr_d   = ovr_q;
        if (clr_overrun) begin
            ovr_d = 1'b0;
        end
        case (state_q)
            EMPTY: begin
                if (wc) begin
                    out_d   = word;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (wc) begin
                    if (data_ready) begin
                        out_d = word;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else if (data_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign data_out   = out_q;
    assign data_valid = (state_q == FULL);
    assign bit_cnt    = cnt_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_regfile_shift_capture.sv
// tb/tb_regfile_shift_capture.sv - directed bench with a word-level model of the shift capture receiver
module tb_regfile_shift_capture;

    localparam int DW = 192;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          shift_in = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          data_ready = 1'b0;
    logic [CW-1:0] bit_cnt;
    logic          overrun;
    logic          clr_overrun = 1'b0;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    regfile_shift_capture #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .shift_in   (shift_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .bit_cnt    (bit_cnt),
        .overrun    (overrun),
        .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;

    // Model: bits fill a word from the top by position; a word is done after DW enabled bits.
    int            m_nbits = 0;
    logic [DW-1:0] m_partial = '0;
    logic [DW-1:0] m_out = '0;
    bit            m_valid = 1'b0;
    bit            m_ovr = 1'b0;

    always @(posedge clk) begin : model
        logic [DW-1:0] w;
        bit            done;
        if (rst) begin
            m_nbits   = 0;
            m_partial = '0;
            m_out     = '0;
            m_valid   = 1'b0;
            m_ovr     = 1'b0;
        end else begin
            done = 1'b0;
            w    = m_partial;
            if (en) begin
                w[DW-1-m_nbits] = shift_in;
                if (m_nbits == DW - 1) begin
                    done      = 1'b1;
                    m_nbits   = 0;
                    m_partial = '0;
                end else begin
                    m_nbits   = m_nbits + 1;
                    m_partial = w;
                end
            end
            if (clr_overrun) m_ovr = 1'b0;
            if (!m_valid) begin
                if (done) begin
                    m_out   = w;
                    m_valid = 1'b1;
                end
            end else if (done) begin
                if (data_ready) m_out = w;
                else m_ovr = 1'b1;
            end else if (data_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            checks = checks + 4;
            if (data_out !== m_out) begin
                errors = errors + 1;
                $display("FAIL cmp_data_out t=%0t got %h expected %h", $time, data_out, m_out);
            end
            if (data_valid !== m_valid) begin
                errors = errors + 1;
                $display("FAIL cmp_data_valid t=%0t got %b expected %b", $time, data_valid, m_valid);
            end
            if (bit_cnt !== CW'(m_nbits)) begin
                errors = errors + 1;
                $display("FAIL cmp_bit_cnt t=%0t got %0d expected %0d", $time, bit_cnt, m_nbits);
            end
            if (overrun !== m_ovr) begin
                errors = errors + 1;
                $display("FAIL cmp_overrun t=%0t got %b expected %b", $time, overrun, m_ovr);
            end
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic e, input logic s, input logic r, input logic c, input logic x);
        en          = e;
        shift_in    = s;
        data_ready  = r;
        clr_overrun = c;
        rst         = x;
        @(negedge clk);
    endtask

    task automatic send(input logic [DW-1:0] w, input logic rdy_rest, input logic rdy_last,
                        input logic clr_last);
        for (int i = DW - 1; i >= 0; i--) begin
            if (i == 0) cyc(1'b1, w[i], rdy_last, clr_last, 1'b0);
            else        cyc(1'b1, w[i], rdy_rest, 1'b0, 1'b0);
        end
    endtask

    localparam logic [DW-1:0] V = 192'h123456789123456789ABCDEF123456789123456789ABCDEF;
    localparam logic [DW-1:0] A = 192'h1;
    localparam logic [DW-1:0] B = 192'h2;
    localparam logic [DW-1:0] F = {DW{1'b1}};
    localparam logic [DW-1:0] C = 192'hDEADBEEF0123456789ABCDEFFEDCBA9876543210CAFEF00D;

    initial begin
        logic [DW-1:0] v;
        v = V;

        // Reset for two edges
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checking = 1'b1;
        chk("reset_data_out", data_out, '0);
        chk("reset_data_valid", DW'(data_valid), '0);
        chk("reset_bit_cnt", DW'(bit_cnt), '0);
        chk("reset_overrun", DW'(overrun), '0);

        // Continuous stream with the consumer always ready
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send(V, 1'b1, 1'b1, 1'b0);
        chk("t2_valid", DW'(data_valid), DW'(1));
        chk("t2_data_out", data_out, V);
        chk("t2_bit_cnt", DW'(bit_cnt), '0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t2_valid_drop", DW'(data_valid), '0);

        // Enable toggling every cycle
        for (int i = DW - 1; i >= 0; i--) begin
            cyc(1'b1, v[i], 1'b0, 1'b0, 1'b0);
            if (i == 96) chk("t3_bit_cnt_mid", DW'(bit_cnt), DW'(96));
            if (i != 0) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            if (i == 96) chk("t3_bit_cnt_hold", DW'(bit_cnt), DW'(96));
        end
        chk("t3_data_out", data_out, V);
        chk("t3_valid", DW'(data_valid), DW'(1));
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Overrun while the consumer stalls; clear on the dropping edge loses to the set
        send(A, 1'b0, 1'b0, 1'b0);
        chk("t4_valid_a", DW'(data_valid), DW'(1));
        chk("t4_data_out_a", data_out, A);
        send(B, 1'b0, 1'b0, 1'b1);
        chk("t4_overrun", DW'(overrun), DW'(1));
        chk("t4_data_out_still_a", data_out, A);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_overrun_clr", DW'(overrun), '0);
        chk("t4_valid_held", DW'(data_valid), DW'(1));

        // Accept on the very edge that completes the replacement word
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send(A, 1'b0, 1'b0, 1'b0);
        send(F, 1'b0, 1'b1, 1'b0);
        chk("t5_data_out_b", data_out, F);
        chk("t5_valid", DW'(data_valid), DW'(1));
        chk("t5_overrun", DW'(overrun), '0);

        // Reset mid-word, then a clean word
        for (int i = DW - 1; i >= DW - 100; i--) cyc(1'b1, C[i], 1'b0, 1'b0, 1'b0);
        chk("t6_bit_cnt_100", DW'(bit_cnt), DW'(100));
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t6_bit_cnt_rst", DW'(bit_cnt), '0);
        chk("t6_valid_rst", DW'(data_valid), '0);
        send(C, 1'b1, 1'b1, 1'b0);
        chk("t6_data_out", data_out, C);
        chk("t6_valid", DW'(data_valid), DW'(1));
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
